// File: rtl/vote_button_conditioner.sv
// vote_button_conditioner
//   Input stage for the voting machine core. Each raw button and the mode
//   switch pass through a 2-flop synchroniser. Each button is then debounced
//   by a per-button counter. A small FSM turns debounced rises into single
//   cycle vote pulses and rejects presses that involve more than one button.
//
//   Optional build macro: VOTE_TOTAL_EN adds total_votes, a saturating count
//   of vote pulses.
//
// Ports
//   clock        system clock, rising edge
//   reset        asynchronous, active-high, clears all state
//   mode         raw mode switch (0 = voting, 1 = result display)
//   button1..4   raw candidate buttons, active-high, bouncy
//   mode_sync    synchronised mode (2nd synchroniser flop, no debounce)
//   vote1..4     one-cycle accepted-vote pulse per candidate
//   multi_err    one-cycle pulse, press rejected (more than one button)
//   busy         high while the FSM is not in IDLE
//   total_votes  [7:0] saturating vote count (VOTE_TOTAL_EN only)
//
// FSM states
//   state  | meaning
//   IDLE   | all debounced levels 0, ready for a press
//   HELD   | one press accepted, waiting for every button to release
//   REJECT | invalid press seen, waiting for every button to release

module vote_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int CNT_W           = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       mode,
    input  logic       button1,
    input  logic       button2,
    input  logic       button3,
    input  logic       button4,
    output logic       mode_sync,
    output logic       vote1,
    output logic       vote2,
    output logic       vote3,
    output logic       vote4,
    output logic       multi_err,
`ifdef VOTE_TOTAL_EN
    output logic [7:0] total_votes,
`endif
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REJECT = 2'd2
    } state_t;

    // The debounced level flips on the edge where the counter would reach
    // DEBOUNCE_CYCLES, so compare against one less than that.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       btn_raw;
    logic [3:0]       btn_meta;
    logic [3:0]       btn_sync;
    logic             mode_meta;
    logic [3:0]       deb;
    logic [3:0]       deb_next;
    logic [3:0]       rise;
    logic [CNT_W-1:0] cnt      [4];
    logic [CNT_W-1:0] cnt_next [4];

    state_t           state;
    state_t           state_next;
    logic [3:0]       vote_q;
    logic [3:0]       vote_next;
    logic             err_next;
    logic             rise_any;
    logic             rise_multi;

    assign btn_raw = {button4, button3, button2, button1};

    // Synchronisers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            btn_meta  <= '0;
            btn_sync  <= '0;
            mode_meta <= 1'b0;
            mode_sync <= 1'b0;
        end else begin
            btn_meta  <= btn_raw;
            btn_sync  <= btn_meta;
            mode_meta <= mode;
            mode_sync <= mode_meta;
        end
    end

    // Debounce: count consecutive disagreeing cycles, clear on agreement.
    always_comb begin
        deb_next = deb;
        for (int i = 0; i < 4; i++) begin
            cnt_next[i] = '0;
            if (btn_sync[i] != deb[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    deb_next[i] = btn_sync[i];
                end else begin
                    cnt_next[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            deb <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            deb <= deb_next;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

    // Rises are decided combinationally so the vote pulse is registered on
    // the same edge as the debounced rise itself.
    assign rise       = deb_next & ~deb;
    assign rise_any   = (rise != 4'd0);
    assign rise_multi = ((rise & (rise - 4'd1)) != 4'd0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            vote_q    <= '0;
            multi_err <= 1'b0;
        end else begin
            state     <= state_next;
            vote_q    <= vote_next;
            multi_err <= err_next;
        end
    end

    always_comb begin
        state_next = state;
        vote_next  = '0;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                if (rise_multi) begin
                    err_next   = 1'b1;
                    state_next = REJECT;
                end else if (rise_any) begin
                    // Mode is taken from the acceptance edge only.
                    if (!mode_sync) begin
                        vote_next = rise;
                    end
                    state_next = HELD;
                end
            end
            HELD: begin
                if (rise_any) begin
                    err_next   = 1'b1;
                    state_next = REJECT;
                end else if (deb_next == 4'd0) begin
                    state_next = IDLE;
                end
            end
            REJECT: begin
                if (rise_any) begin
                    err_next = 1'b1;
                end
                if (deb_next == 4'd0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign vote1 = vote_q[0];
    assign vote2 = vote_q[1];
    assign vote3 = vote_q[2];
    assign vote4 = vote_q[3];
    assign busy  = (state != IDLE);

`ifdef VOTE_TOTAL_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            total_votes <= 8'd0;
        end else if ((vote_q != 4'd0) && (total_votes != 8'hFF)) begin
            total_votes <= total_votes + 8'd1;
        end
    end
`endif

endmodule

// File: doc/vote_button_conditioner.md
Name: vote_button_conditioner

Overview:
Upstream input stage for the voting machine core. Synchronises and debounces the four raw candidate buttons and the mode switch. Enforces the one-voter-one-press rule and emits exactly one single-cycle vote pulse per accepted press. The core's vote counters consume these pulses directly instead of raw button levels.

Parameters:
DEBOUNCE_CYCLES, 8, consecutive clock cycles a synchronised level must hold before the debounced level changes (legal range 2..255)
CNT_W, 8, width of each debounce counter; must hold DEBOUNCE_CYCLES

Ports:
clock  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high; clears all state
mode  input  1  raw mode switch (0 = voting, 1 = result display)
button1  input  1  raw candidate-1 button, active-high, asynchronous/bouncy
button2  input  1  raw candidate-2 button
button3  input  1  raw candidate-3 button
button4  input  1  raw candidate-4 button
mode_sync  output  1  two-flop synchronised mode
vote1  output  1  one-cycle accepted-vote pulse, candidate 1
vote2  output  1  one-cycle accepted-vote pulse, candidate 2
vote3  output  1  one-cycle accepted-vote pulse, candidate 3
vote4  output  1  one-cycle accepted-vote pulse, candidate 4
multi_err  output  1  one-cycle pulse: press rejected (more than one button)
busy  output  1  high while FSM not in IDLE

Behaviour:
- Clock and reset: one clock, `clock`. Reset `reset` is asynchronous and active-high.
- Reset values: all outputs 0, synchronisers 0, debounced levels 0, counters 0, FSM = IDLE. Reset asserted mid-operation aborts any pending pulse; nothing fires after release until a fresh debounced press.
- Synchronisers: every raw input (mode, button1..4) passes through a 2-flop synchroniser.
- mode_sync: equals the 2nd synchroniser flop of mode; no debounce.
- Debounce, per button:
  - Counter increments each cycle the synchronised level differs from the debounced level.
  - Counter clears to 0 on any cycle they agree.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the synchronised value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes the debounced level.
- Latency: let E0 be the first rising edge that samples a raw button high. The debounced rise, and any vote pulse, are registered at edge E0+DEBOUNCE_CYCLES+1. With the default, the pulse is high for the cycle after E0+9.
- Rise set: the set of buttons whose debounced level goes 0->1 on a given edge.
- FSM states:
  - IDLE: all debounced levels 0.
  - HELD: one press accepted, waiting for release.
  - REJECT: invalid press, waiting for release.
- IDLE transitions:
  - Exactly one rise, others debounced 0, mode_sync=0: assert that voteN for one cycle, go HELD.
  - Exactly one rise with mode_sync=1: no pulse, go HELD.
  - Two or more rises on the same edge: multi_err for one cycle, no vote, go REJECT.
- HELD: any additional debounced rise causes multi_err for one cycle and a move to REJECT. No further vote is issued. All debounced levels 0 returns to IDLE.
- REJECT: stays until all debounced levels are 0, then IDLE. No pulses except further multi_err on new rises.
- Pulse width: vote1..4 are never high for more than one cycle. Holding a button indefinitely yields one vote. At most one voteN is high in any cycle.
- Mode change: mode_sync is sampled on the acceptance edge. A mode change while HELD has no retroactive effect.
- busy is 1 in HELD and REJECT.

Optional Feature:
VOTE_TOTAL_EN
- Defined: adds output total_votes [7:0].
  - Increments on every cycle any voteN is high.
  - Saturates at 255 (no wrap). Reset to 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset held 10 cycles, then released with all inputs low -> all outputs 0, busy=0, FSM IDLE.
- button1 high for 20 cycles, then low (DEBOUNCE_CYCLES=8) -> vote1 high exactly one cycle, after edge E0+9; busy high until 9 cycles after release. With VOTE_TOTAL_EN, total_votes=1.
- button2 glitch high 5 cycles, low 3, high 5, then low -> no vote pulse, busy stays 0.
- button2 and button3 raised on the same cycle, held 20 cycles -> multi_err one cycle, no voteN, busy=1 until both released and debounced.
- mode=1 for 20 cycles, then button2 pressed 20 cycles -> mode_sync=1, no vote2, busy cycles 1->0. Then mode=0 and press button3 -> vote3 one pulse.
- button4 held, reset pulsed 2 cycles mid-debounce (counter=4), button4 kept high -> reset clears state. A vote4 pulse appears only DEBOUNCE_CYCLES+1 edges after the first post-reset sampling edge, exactly once.
